// File: rtl/bus_condition_timers.sv
// rtl/bus_condition_timers.sv - I3C bus quiet-time tracker raising Bus Free / Available / Idle
//
// Counts clk_i cycles of bus quiet time after a STOP (or after enable) and
// compares the count live against three CSR thresholds.
//
// Parameters:
//   CntWidth           width of the quiet-time counter and all thresholds
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   enable_i           block enable (PHY enable)
//   t_bus_free_i       Bus Free threshold in clk cycles
//   t_bus_available_i  Bus Available threshold in clk cycles
//   t_bus_idle_i       Bus Idle threshold in clk cycles
//   scl_i, sda_i       synchronised bus line levels
//   start_det_i        1-cycle pulse, START / Repeated START seen
//   stop_det_i         1-cycle pulse, STOP seen
//   bus_busy_o         bus between START and STOP
//   bus_free_o         Bus Free condition reached
//   bus_available_o    Bus Available condition reached
//   bus_idle_o         Bus Idle condition reached
//   quiet_cnt_o        current quiet-time count
//
// Optional feature (macro I3C_BUS_COND_PULSE_EN):
//   bus_free_pulse_o, bus_available_pulse_o, bus_idle_pulse_o
//   registered 1-cycle pulses one cycle after each level flag rises.

module bus_condition_timers #(
  parameter int CntWidth = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic [CntWidth-1:0] t_bus_free_i,
  input  logic [CntWidth-1:0] t_bus_available_i,
  input  logic [CntWidth-1:0] t_bus_idle_i,
  input  logic                scl_i,
  input  logic                sda_i,
  input  logic                start_det_i,
  input  logic                stop_det_i,
  output logic                bus_busy_o,
  output logic                bus_free_o,
  output logic                bus_available_o,
  output logic                bus_idle_o,
  output logic [CntWidth-1:0] quiet_cnt_o
`ifdef I3C_BUS_COND_PULSE_EN
  ,
  output logic                bus_free_pulse_o,
  output logic                bus_available_pulse_o,
  output logic                bus_idle_pulse_o
`endif
);

  localparam logic [1:0] StDisabled = 2'd0;
  localparam logic [1:0] StBusy     = 2'd1;
  localparam logic [1:0] StCount    = 2'd2;

  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (!enable_i) begin
      state_d = StDisabled;
    end else begin
      case (state_q)
        // Coming out of disable the bus is assumed quiet since power-up,
        // so Hot-Join can wait for Bus Idle without having seen a STOP.
        StDisabled: state_d = StCount;
        StBusy: begin
          if (start_det_i)     state_d = StBusy;
          else if (stop_det_i) state_d = StCount;
        end
        StCount: begin
          if (start_det_i) begin
            state_d = StBusy;
          end else if (stop_det_i) begin
            state_d = StCount;   // re-arm the count from zero
          end else if (!scl_i || !sda_i) begin
            state_d = StBusy;    // any low line ends the quiet period
          end else begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntWidth'(1'b1);
          end
        end
        default: state_d = StDisabled;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StDisabled;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Thresholds are compared live so a CSR rewrite is seen immediately.
  assign bus_busy_o      = (state_q == StBusy);
  assign bus_free_o      = (state_q == StCount) && (cnt_q >= t_bus_free_i);
  assign bus_available_o = (state_q == StCount) && (cnt_q >= t_bus_available_i);
  assign bus_idle_o      = (state_q == StCount) && (cnt_q >= t_bus_idle_i);
  assign quiet_cnt_o     = cnt_q;

`ifdef I3C_BUS_COND_PULSE_EN
  logic [2:0] flags_now, flags_q, pulse_q;

  assign flags_now = {bus_free_o, bus_available_o, bus_idle_o};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= '0;
      pulse_q <= '0;
    end else begin
      flags_q <= flags_now;
      pulse_q <= flags_now & ~flags_q;   // rising edges only
    end
  end

  assign bus_free_pulse_o      = pulse_q[2];
  assign bus_available_pulse_o = pulse_q[1];
  assign bus_idle_pulse_o      = pulse_q[0];
`endif

endmodule

// File: tb/tb_bus_condition_timers.sv
// tb/tb_bus_condition_timers.sv - self-checking bench for bus_condition_timers

module tb_bus_condition_timers;

  localparam int W = 10;
  localparam logic [1:0] MD = 2'd0, MB = 2'd1, MC = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, en, scl, sda, start, stop;
  logic [W-1:0] t_free, t_aval, t_idle;
  logic         busy, free, aval, idle;
  logic [W-1:0] qcnt;
`ifdef I3C_BUS_COND_PULSE_EN
  logic         fp, ap, ip;
`endif

  bus_condition_timers #(.CntWidth(W)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .enable_i          (en),
    .t_bus_free_i      (t_free),
    .t_bus_available_i (t_aval),
    .t_bus_idle_i      (t_idle),
    .scl_i             (scl),
    .sda_i             (sda),
    .start_det_i       (start),
    .stop_det_i        (stop),
    .bus_busy_o        (busy),
    .bus_free_o        (free),
    .bus_available_o   (aval),
    .bus_idle_o        (idle),
    .quiet_cnt_o       (qcnt)
`ifdef I3C_BUS_COND_PULSE_EN
    ,
    .bus_free_pulse_o      (fp),
    .bus_available_pulse_o (ap),
    .bus_idle_pulse_o      (ip)
`endif
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [W+6:0] sb[$];   // {pulses[2:0], busy, free, aval, idle, cnt}
  logic [1:0]   m_state;
  logic [W-1:0] m_cnt;
  logic [2:0]   m_flags_q, m_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_flags();
    m_flags = {3{m_state == MC}} & {m_cnt >= t_free, m_cnt >= t_aval, m_cnt >= t_idle};
  endfunction

  task automatic model_step();
    logic [2:0] f;
    f         = m_flags();
    m_pulse   = f & ~m_flags_q;
    m_flags_q = f;
    if (!en) begin
      m_state = MD; m_cnt = '0;
    end else if (m_state == MD) begin
      m_state = MC; m_cnt = '0;
    end else if (start) begin
      m_state = MB; m_cnt = '0;
    end else if (stop) begin
      m_state = MC; m_cnt = '0;
    end else if (m_state == MC && (!scl || !sda)) begin
      m_state = MB; m_cnt = '0;
    end else if (m_state == MC) begin
      if (m_cnt != '1) m_cnt = m_cnt + W'(1);
    end else begin
      m_cnt = '0;
    end
  endtask

  task automatic tick();
    logic [W+6:0] e, o;
    @(posedge clk);
    model_step();
`ifdef I3C_BUS_COND_PULSE_EN
    sb.push_back({m_pulse, m_state == MB, m_flags(), m_cnt});
`else
    sb.push_back({3'b000, m_state == MB, m_flags(), m_cnt});
`endif
    #1;
    e = sb.pop_front();
`ifdef I3C_BUS_COND_PULSE_EN
    o = {fp, ap, ip, busy, free, aval, idle, qcnt};
`else
    o = {3'b000, busy, free, aval, idle, qcnt};
`endif
    check("cycle", 32'(o), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; scl = 1'b1; sda = 1'b1; start = 1'b0; stop = 1'b0;
    t_free = W'(4); t_aval = W'(10); t_idle = W'(20);
    m_state = MD; m_cnt = '0; m_flags_q = '0; m_pulse = '0;

    #12;
    check("reset_outs", 32'({busy, free, aval, idle, qcnt}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("disabled_after_release", 32'({busy, free, aval, idle, qcnt}), 32'd0);

    // Power-up quiet count: flags at 4 / 10 / 20.
    repeat (4) tick();
    check("free_before_4", 32'({qcnt, free}), 32'({W'(3), 1'b0}));
    tick();
    check("free_at_4", 32'({qcnt, free, aval}), 32'({W'(4), 2'b10}));
    repeat (16) tick();
    check("idle_at_20", 32'({qcnt, free, aval, idle}), 32'({W'(20), 3'b111}));

    // Transaction: START, 30 busy cycles, STOP with Bus Free = 3.
    t_free = W'(3);
    start = 1'b1; tick(); start = 1'b0;
    check("busy_after_start", 32'({busy, qcnt}), 32'({1'b1, W'(0)}));
    repeat (30) tick();
    check("still_busy", 32'(busy), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("quiet_after_stop", 32'({busy, qcnt}), 32'({1'b0, W'(0)}));
    repeat (2) tick();
    check("free_not_yet", 32'(free), 32'd0);
    tick();
    check("free_4_after_stop", 32'({free, aval}), 32'({1'b1, 1'b0}));

    // Live threshold: raising it drops the flag without a clock edge.
    t_free = W'(9); #1;
    check("live_raise", 32'(free), 32'd0);
    t_free = W'(3); #1;
    check("live_restore", 32'(free), 32'd1);

    // SCL low at cnt=7 ends the quiet period until the next STOP.
    repeat (4) tick();
    check("cnt_7", 32'(qcnt), 32'd7);
    scl = 1'b0; tick(); scl = 1'b1;
    check("scl_low_busy", 32'({busy, free, aval, idle, qcnt}), 32'({1'b1, 3'b000, W'(0)}));
    repeat (5) tick();
    check("no_resume", 32'({busy, qcnt}), 32'({1'b1, W'(0)}));
    stop = 1'b1; tick(); stop = 1'b0;

    // START wins over a simultaneous STOP.
    repeat (3) tick();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("start_over_stop", 32'({busy, qcnt}), 32'({1'b1, W'(0)}));
    sda = 1'b0; tick(); sda = 1'b1;
    stop = 1'b1; tick(); stop = 1'b0;

    // Enable drop mid-count.
    repeat (12) tick();
    check("cnt_12", 32'(qcnt), 32'd12);
    en = 1'b0; tick();
    check("disabled_outs", 32'({busy, free, aval, idle, qcnt}), 32'd0);
    tick();
    en = 1'b1; tick();
    check("reenable_count", 32'({busy, qcnt}), 32'({1'b0, W'(0)}));

    // Saturation with all thresholds at the counter maximum.
    t_free = '1; t_aval = '1; t_idle = '1;
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (1022) tick();
    check("below_max", 32'({qcnt, free, aval, idle}), 32'({W'(1022), 3'b000}));
    tick();
    check("at_max", 32'({qcnt, free, aval, idle}), 32'({{W{1'b1}}, 3'b111}));
    repeat (6) tick();
    check("saturated", 32'({qcnt, free, aval, idle}), 32'({{W{1'b1}}, 3'b111}));

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
